// File: rtl/decode_issue.sv
// Decode/issue stage: register file, scoreboard, operand formation,
// and a registered valid/ready issue slot toward the ALU.
module decode_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] instr,
    input  logic [15:0] pc_in,
    input  logic        wb_en,
    input  logic [3:0]  wb_reg,
    input  logic [15:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  alu_opcode,
    output logic [15:0] alu_in1,
    output logic [15:0] alu_in2,
    output logic [3:0]  dst_reg,
    output logic        reg_wr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] store_data,
    output logic        halted
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t      state;
    logic [15:0] rf [16];
    logic [15:0] busy;
    logic [15:0] busy_eff;
    logic [15:0] wb_clr;
    logic [15:0] set_mask;

    logic [3:0]  op, rd, rs, rt;
    logic [15:0] rs_val, rt_val, rd_val;
    logic [15:0] sext;

    logic        use_rs, use_rt, use_rd;
    logic        wr_op, mr_d, mw_d;
    logic        wr_d;
    logic [15:0] in1_d, in2_d, sd_d;
    logic        hazard;
    logic        accept;

    assign op = instr[15:12];
    assign rd = instr[11:8];
    assign rs = instr[7:4];
    assign rt = instr[3:0];

    // Reads see a same-cycle writeback; R0 is hardwired to zero
    assign rs_val = (rs == 4'd0) ? 16'h0000 :
                    (wb_en && wb_reg == rs) ? wb_data : rf[rs];
    assign rt_val = (rt == 4'd0) ? 16'h0000 :
                    (wb_en && wb_reg == rt) ? wb_data : rf[rt];
    assign rd_val = (rd == 4'd0) ? 16'h0000 :
                    (wb_en && wb_reg == rd) ? wb_data : rf[rd];

    assign sext = {{11{rt[3]}}, rt, 1'b0};

    always_comb begin
        use_rs = 1'b0;
        use_rt = 1'b0;
        use_rd = 1'b0;
        wr_op  = 1'b0;
        mr_d   = 1'b0;
        mw_d   = 1'b0;
        in1_d  = 16'h0000;
        in2_d  = 16'h0000;
        sd_d   = 16'h0000;
        unique case (op)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h7: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
                wr_op  = 1'b1;
                in1_d  = rs_val;
                in2_d  = rt_val;
            end
            4'h4, 4'h5, 4'h6: begin
                use_rs = 1'b1;
                wr_op  = 1'b1;
                in1_d  = rs_val;
                in2_d  = {12'h000, rt};
            end
            4'h8: begin
                use_rs = 1'b1;
                wr_op  = 1'b1;
                mr_d   = 1'b1;
                in1_d  = rs_val & 16'hFFFE;
                in2_d  = sext;
            end
            4'h9: begin
                use_rs = 1'b1;
                use_rd = 1'b1;
                mw_d   = 1'b1;
                in1_d  = rs_val & 16'hFFFE;
                in2_d  = sext;
                sd_d   = rd_val;
            end
            4'hA: begin
                use_rd = 1'b1;
                wr_op  = 1'b1;
                in1_d  = rd_val;
                in2_d  = {8'h00, instr[7:0]};
            end
            4'hB: begin
                use_rd = 1'b1;
                wr_op  = 1'b1;
                in1_d  = rd_val;
                in2_d  = {instr[7:0], 8'h00};
            end
            4'hC: begin
                use_rs = 1'b1;
                in1_d  = rs_val;
            end
            4'hE: begin
                wr_op  = 1'b1;
                in1_d  = pc_in + 16'd2;
            end
            default: begin
            end
        endcase
    end

    assign wr_d = wr_op & (rd != 4'd0);

    // A writeback this cycle releases its register before hazard check
    assign wb_clr   = wb_en ? (16'd1 << wb_reg) : 16'h0000;
    assign busy_eff = busy & ~wb_clr;
    assign set_mask = (accept && wr_d) ? (16'd1 << rd) : 16'h0000;

    assign hazard = busy_eff[rd]
                  | (use_rs & busy_eff[rs])
                  | (use_rt & busy_eff[rt])
                  | (use_rd & busy_eff[rd]);

    assign in_ready = ~halted & ~hazard & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign halted   = (state == HALTED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) rf[i] <= 16'h0000;
        end else if (wb_en && wb_reg != 4'd0) begin
            rf[wb_reg] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= 16'h0000;
        else     busy <= ((busy & ~wb_clr) | set_mask) & 16'hFFFE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            out_valid  <= 1'b0;
            alu_opcode <= 4'h0;
            alu_in1    <= 16'h0000;
            alu_in2    <= 16'h0000;
            dst_reg    <= 4'h0;
            reg_wr     <= 1'b0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            store_data <= 16'h0000;
        end else begin
            if (accept) begin
                out_valid  <= 1'b1;
                alu_opcode <= op;
                alu_in1    <= in1_d;
                alu_in2    <= in2_d;
                dst_reg    <= rd;
                reg_wr     <= wr_d;
                mem_rd     <= mr_d;
                mem_wr     <= mw_d;
                store_data <= sd_d;
                if (op == 4'hF) state <= HALTED;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: per-cycle vector table plus
// hand sequences for backpressure, halt and asynchronous reset.
module tb_decode_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic [15:0] pc_in;
    logic        wb_en;
    logic [3:0]  wb_reg;
    logic [15:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_in1;
    logic [15:0] alu_in2;
    logic [3:0]  dst_reg;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] store_data;
    logic        halted;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        ov;
        logic [3:0]  op;
        logic [15:0] in1;
        logic [15:0] in2;
        logic [3:0]  dst;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [15:0] sd;
        logic        h;
    } out_t;

    typedef struct {
        logic        iv;
        logic [15:0] ins;
        logic        wbe;
        logic [3:0]  wr;
        logic [15:0] wd;
        logic        rdy;
        out_t        exp;
    } vec_t;

    vec_t tbl[$];

    decode_issue dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc_in(pc_in),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_opcode(alu_opcode), .alu_in1(alu_in1),
        .alu_in2(alu_in2), .dst_reg(dst_reg),
        .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .store_data(store_data), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic out_t mo(
        input logic ov, input logic [3:0] op,
        input logic [15:0] a, input logic [15:0] b,
        input logic [3:0] d, input logic rw,
        input logic mr, input logic mw,
        input logic [15:0] sd, input logic h);
        out_t o;
        o = '{ov, op, a, b, d, rw, mr, mw, sd, h};
        return o;
    endfunction

    function automatic vec_t mk(
        input logic iv, input logic [15:0] ins,
        input logic wbe, input logic [3:0] wr,
        input logic [15:0] wd, input logic rdy,
        input logic ov, input logic [3:0] op,
        input logic [15:0] a, input logic [15:0] b,
        input logic [3:0] d, input logic rw,
        input logic mr, input logic mw,
        input logic [15:0] sd);
        vec_t v;
        v.iv  = iv;
        v.ins = ins;
        v.wbe = wbe;
        v.wr  = wr;
        v.wd  = wd;
        v.rdy = rdy;
        v.exp = mo(ov, op, a, b, d, rw, mr, mw, sd, 1'b0);
        return v;
    endfunction

    function automatic out_t cur();
        return mo(out_valid, alu_opcode, alu_in1, alu_in2,
                  dst_reg, reg_wr, mem_rd, mem_wr,
                  store_data, halted);
    endfunction

    task automatic chk_rdy(input string nm, input logic exp);
        checks++;
        if (in_ready !== exp) begin
            errors++;
            $display("FAIL %s in_ready: got %b expected %b",
                     nm, in_ready, exp);
        end
    endtask

    task automatic chk_out(input string nm, input out_t exp);
        out_t act;
        act = cur();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s outputs: got %h expected %h",
                     nm, act, exp);
        end
    endtask

    task automatic step(
        input string nm, input logic iv,
        input logic [15:0] ins, input logic [15:0] pc,
        input logic ordy, input logic wbe,
        input logic [3:0] wr, input logic [15:0] wd,
        input logic exp_rdy, input out_t exp);
        @(negedge clk);
        in_valid  = iv;
        instr     = ins;
        pc_in     = pc;
        out_ready = ordy;
        wb_en     = wbe;
        wb_reg    = wr;
        wb_data   = wd;
        #1 chk_rdy(nm, exp_rdy);
        @(posedge clk);
        #1 chk_out(nm, exp);
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        instr     = 16'h0000;
        pc_in     = 16'h0000;
        out_ready = 1'b1;
        wb_en     = 1'b0;
        wb_reg    = 4'h0;
        wb_data   = 16'h0000;
    endtask

    initial begin
        out_t z;
        z = mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        idle_inputs();

        // iv ins wbe wr wd | rdy | ov op in1 in2 dst rw mr mw sd
        tbl.push_back(mk(0,16'h0000,1,1,16'h0005, 1, 0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,16'h0000,1,2,16'h0003, 1, 0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,16'h0312,0,0,0, 1, 1,0,5,3,3,1,0,0,0));
        tbl.push_back(mk(1,16'h1431,0,0,0, 0, 0,0,5,3,3,1,0,0,0));
        tbl.push_back(mk(1,16'h1431,0,0,0, 0, 0,0,5,3,3,1,0,0,0));
        tbl.push_back(mk(1,16'h1431,1,3,16'h0008, 1, 1,1,8,5,4,1,0,0,0));
        tbl.push_back(mk(0,16'h0000,1,4,16'h0003, 1, 0,1,8,5,4,1,0,0,0));
        tbl.push_back(mk(0,16'h0000,1,5,16'h1234, 1, 0,1,8,5,4,1,0,0,0));
        tbl.push_back(mk(0,16'h0000,1,6,16'hBEEF, 1, 0,1,8,5,4,1,0,0,0));
        tbl.push_back(mk(1,16'hA5AB,0,0,0, 1,
                         1,4'hA,16'h1234,16'h00AB,5,1,0,0,0));
        tbl.push_back(mk(1,16'h965F,1,5,16'h12AB, 1,
                         1,4'h9,16'h12AA,16'hFFFE,6,0,0,1,16'hBEEF));
        tbl.push_back(mk(1,16'h8712,0,0,0, 1, 1,8,4,4,7,1,1,0,0));
        tbl.push_back(mk(1,16'h4813,0,0,0, 1, 1,4,5,3,8,1,0,0,0));
        tbl.push_back(mk(1,16'h0012,0,0,0, 1, 1,0,5,3,0,0,0,0,0));
        tbl.push_back(mk(1,16'h0900,0,0,0, 1, 1,0,0,0,9,1,0,0,0));
        tbl.push_back(mk(1,16'h0712,0,0,0, 0, 0,0,0,0,9,1,0,0,0));
        tbl.push_back(mk(1,16'h0712,1,7,16'h0055, 1, 1,0,5,3,7,1,0,0,0));
        tbl.push_back(mk(1,16'h0A70,0,0,0, 0, 0,0,5,3,7,1,0,0,0));
        tbl.push_back(mk(1,16'h0A70,1,7,16'h0077, 1,
                         1,0,16'h0077,0,4'hA,1,0,0,0));
        tbl.push_back(mk(1,16'hC310,0,0,0, 1, 1,4'hC,5,0,3,0,0,0,0));
        tbl.push_back(mk(1,16'hB212,0,0,0, 1,
                         1,4'hB,3,16'h1200,2,1,0,0,0));
        tbl.push_back(mk(0,16'h0000,0,0,0, 1,
                         0,4'hB,3,16'h1200,2,1,0,0,0));

        repeat (2) @(negedge clk);
        #1 chk_out("reset", z);
        chk_rdy("reset", 1'b1);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("row%0d", i), tbl[i].iv, tbl[i].ins,
                 16'h0000, 1'b1, tbl[i].wbe, tbl[i].wr,
                 tbl[i].wd, tbl[i].rdy, tbl[i].exp);
        end

        // PCS wraps the PC, then holds under backpressure
        step("pcs", 1, 16'hE700, 16'hFFFE, 0, 0, 0, 0, 1,
             mo(1, 4'hE, 0, 0, 7, 1, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            step($sformatf("hold%0d", i), 1, 16'h0110, 16'h0000,
                 0, 0, 0, 0, 0,
                 mo(1, 4'hE, 0, 0, 7, 1, 0, 0, 0, 0));
        end
        step("nobubble", 1, 16'h0B10, 0, 1, 0, 0, 0, 1,
             mo(1, 0, 5, 0, 4'hB, 1, 0, 0, 0, 0));
        step("drain", 0, 0, 0, 1, 0, 0, 0, 1,
             mo(0, 0, 5, 0, 4'hB, 1, 0, 0, 0, 0));

        step("hlt", 1, 16'hF000, 0, 1, 0, 0, 0, 1,
             mo(1, 4'hF, 0, 0, 0, 0, 0, 0, 0, 1));
        for (int i = 0; i < 2; i++) begin
            step($sformatf("halted%0d", i), 1, 16'h0000, 0,
                 1, 0, 0, 0, 0,
                 mo(0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 1));
        end

        // Asynchronous reset between clock edges
        @(negedge clk);
        idle_inputs();
        #2 rst = 1'b1;
        #1 chk_out("async_rst", z);
        chk_rdy("async_rst", 1'b1);
        #1 rst = 1'b0;

        step("post_rst", 1, 16'h0312, 0, 0, 0, 0, 0, 1,
             mo(1, 0, 0, 0, 3, 1, 0, 0, 0, 0));
        @(negedge clk);
        idle_inputs();
        #2 rst = 1'b1;
        #1 chk_out("discard", z);
        #1 rst = 1'b0;
        step("sb_clear", 1, 16'h0313, 0, 1, 0, 0, 0, 1,
             mo(1, 0, 0, 0, 3, 1, 0, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 clk input 1: single clock; all state on rising edge.
REQ-002 rst input 1: reset, asynchronous, active-high.
REQ-003 in_valid input 1, in_ready output 1, instr input 16, pc_in input 16: instruction handshake; instr = opcode[15:12], rd[11:8], rs[7:4], rt/imm[3:0].
REQ-004 wb_en input 1, wb_reg input 4, wb_data input 16: register-file write port from writeback.
REQ-005 out_valid output 1, out_ready input 1: issue handshake toward the ALU stage.
REQ-006 alu_opcode output 4, alu_in1 output 16, alu_in2 output 16: ALU operands, registered.
REQ-007 dst_reg output 4, reg_wr output 1, mem_rd output 1, mem_wr output 1, store_data output 16, halted output 1: registered side-band.

Function
REQ-008 Internal 16x16 register file; R0 reads 0, writes to R0 ignored.
REQ-009 Read in the same cycle as a write to the same register SHALL return wb_data (write-before-read bypass).
REQ-010 Operand formation, alu_opcode = instr[15:12]:
- 0000-0011, 0111: in1=R[rs], in2=R[rt].
- 0100-0110 (SLL/SRA/ROR): in1=R[rs], in2={12'b0, imm4}.
- 1000/1001 (LW/SW): in1=R[rs] & 16'hFFFE, in2=sign-extended imm4 << 1; SW store_data=R[rd].
- 1010 (LLB): in1=R[rd], in2={8'h00, instr[7:0]}; 1011 (LHB): in1=R[rd], in2={instr[7:0], 8'h00}.
- 1110 (PCS): in1=pc_in+2 (mod 2^16), in2=0.
- 1100, 1101, 1111: in1=in2=0 (BR: in1=R[rs]).
REQ-011 reg_wr=1 for opcodes 0000-1000, 1010, 1011, 1110 with rd!=0; else 0. mem_rd=1 only for 1000, mem_wr=1 only for 1001; dst_reg=rd.
REQ-012 Scoreboard: one busy bit per register R1-R15; set on accept of an instruction with reg_wr=1; cleared when wb_en=1 for that register; set and clear same register same cycle: set wins.
REQ-013 Hazard: any read source (per REQ-010) or dst_reg busy and not cleared by wb_en in the same cycle; R0 never busy.
REQ-014 in_ready = ~halted & ~hazard & (~out_valid | out_ready); accept = in_valid & in_ready.
REQ-015 Output register loads on accept; out_valid rises the next cycle, zero bubble when out_ready held high.
REQ-016 out_valid & ~out_ready: all outputs SHALL hold stable.
REQ-017 out_valid clears on out_ready when no new accept in that cycle.
REQ-018 States RUN, HALTED: accept of 1111 SHALL issue it and transition to HALTED; HALTED holds in_ready=0, halted=1 until reset.
REQ-019 in_valid with hazard: no accept, no scoreboard change; instr must be held by source (not latched internally).

Reset
REQ-020 rst asserted: state RUN, out_valid=0, halted=0, all scoreboard bits 0, all registered outputs 0, all registers 0, effective immediately regardless of clk.
REQ-021 rst mid-transfer: pending issued instruction is discarded; no completion.

Verification
REQ-022 wb R1=5, R2=3; issue ADD R3,R1,R2 -> next cycle out_valid=1, alu_in1=5, alu_in2=3, alu_opcode=0, dst_reg=3, reg_wr=1.
REQ-023 Issue ADD R3,R1,R2 then SUB R4,R3,R1 -> second stalls (in_ready=0) until wb_en R3; accepted in the wb cycle with in1 = wb_data.
REQ-024 R5=16'h1234; LLB R5,8'hAB -> in1=16'h1234, in2=16'h00AB, alu_opcode=1010; SW R6,R5,imm4=4'hF -> in2=16'hFFFE, mem_wr=1, store_data=R6.
REQ-025 pc_in=16'hFFFE, PCS R7 -> alu_in1=16'h0000, alu_in2=0; out_ready=0 for 3 cycles -> outputs stable, in_ready=0.
REQ-026 Issue HLT -> issued once, halted=1, in_ready=0 thereafter; rst -> halted=0, in_ready=1.
REQ-027 ADD R0,R1,R2 -> reg_wr=0, no scoreboard bit set; following read of R0 not stalled, reads 0.
